systolic_ctrl: RTL and testbench

- Sequencer for the N×N output-stationary systolic matrix-multiply array.
- On a start request it clears PE accumulators and issues K read beats to the A and B operand buffers.
- Generates per-row and per-column skewed feed enables, waits for the array to flush, then drains the N result rows over a valid/ready interface.
- Sits between the host command interface and the operand buffers, PE array and result writer.

---
 rtl/systolic_ctrl_pkg.sv | 25 ++
 rtl/systolic_ctrl_if.sv | 34 +++
 rtl/systolic_ctrl_skew_line.sv | 34 +++
 rtl/systolic_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constant helpers for the systolic array sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN,
        DONE
    } state_e;

    // Counter width for a value range of x: max(clog2(x), 1).
    function automatic int unsigned cnt_w(input int unsigned x);
        int unsigned w;
        w = 32'($clog2(x));
        return (w < 1) ? 1 : w;
    endfunction

    // Cycles for the last operand to cross the array and leave the PE pipeline.
    function automatic int unsigned flush_cyc(input int unsigned n, input int unsigned pe_lat);
        return 2 * n - 1 + pe_lat;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Command, operand-buffer, skew-enable and result-drain signals of the sequencer.
interface systolic_ctrl_if #(
    parameter int unsigned N = 4,
    parameter int unsigned K = 4
);
    localparam int unsigned KW = systolic_pkg::cnt_w(K);
    localparam int unsigned NW = systolic_pkg::cnt_w(N);

    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          pe_clear;
    logic          rd_en;
    logic [KW-1:0] rd_addr;
    logic [N-1:0]  row_en;
    logic [N-1:0]  col_en;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] drain_row;

    // Sequencer side.
    modport master (
        input  start, abort, out_ready,
        output busy, done, pe_clear, rd_en, rd_addr, row_en, col_en, out_valid, drain_row
    );

    // Host / buffer / result-writer side.
    modport slave (
        output start, abort, out_ready,
        input  busy, done, pe_clear, rd_en, rd_addr, row_en, col_en, out_valid, drain_row
    );

endinterface

// File: rtl/systolic_ctrl_skew_line.sv
// N-bit enable delay line: en[0] is in_en delayed one cycle, en[i] is en[i-1] delayed one cycle.
module skew_line #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_en,
    output logic [N-1:0] en
);

    logic [N-1:0] en_q;
    logic [N-1:0] en_d;

    // Shift toward higher rows/columns; the truncating cast also covers N=1.
    always_comb begin
        en_d = N'({en_q, in_en});
        if (clr) begin
            en_d = '0;
        end
    end

    // Delay-line register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q <= '0;
        end else begin
            en_q <= en_d;
        end
    end

    assign en = en_q;

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic matmul array.
// Optional performance counters are built when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned K      = 4,
    parameter int unsigned PE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SYSTOLIC_CTRL_PERF_EN
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_stalls,
`endif
    systolic_ctrl_if.master bus
);

    localparam int unsigned KW        = cnt_w(K);
    localparam int unsigned NW        = cnt_w(N);
    localparam int unsigned FLUSH_CYC = flush_cyc(N, PE_LAT);
    localparam int unsigned FW        = cnt_w(FLUSH_CYC);

    state_e        state_q, state_d;
    logic [KW-1:0] rd_addr_q, rd_addr_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [NW-1:0] drain_row_q, drain_row_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pe_clear_q, pe_clear_d;
    logic          rd_en_q, rd_en_d;
    logic          out_valid_q, out_valid_d;
    logic          abort_hit_c;
    logic [N-1:0]  row_en;
    logic [N-1:0]  col_en;

    assign abort_hit_c = bus.abort && (state_q != IDLE);

    // Next-state, counter loads and registered-output decode.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        flush_d     = flush_q;
        drain_row_d = drain_row_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = CLEAR;
            end
            CLEAR: begin
                state_d   = FEED;
                rd_addr_d = '0;
            end
            FEED: begin
                if (rd_addr_q == KW'(K - 1)) begin
                    state_d   = FLUSH;
                    rd_addr_d = '0;
                    flush_d   = FW'(FLUSH_CYC - 1);
                end else begin
                    rd_addr_d = rd_addr_q + KW'(1);
                end
            end
            FLUSH: begin
                if (flush_q == '0) begin
                    state_d     = DRAIN;
                    drain_row_d = '0;
                end else begin
                    flush_d = flush_q - FW'(1);
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (drain_row_q == NW'(N - 1)) begin
                        state_d     = DONE;
                        drain_row_d = '0;
                    end else begin
                        drain_row_d = drain_row_q + NW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort_hit_c) begin
            state_d     = IDLE;
            rd_addr_d   = '0;
            flush_d     = '0;
            drain_row_d = '0;
        end
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        pe_clear_d  = (state_d == CLEAR);
        rd_en_d     = (state_d == FEED);
        out_valid_d = (state_d == DRAIN);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            flush_q     <= '0;
            drain_row_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pe_clear_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            flush_q     <= flush_d;
            drain_row_q <= drain_row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pe_clear_q  <= pe_clear_d;
            rd_en_q     <= rd_en_d;
            out_valid_q <= out_valid_d;
        end
    end

    skew_line #(.N(N)) u_row_skew (
        .clk   (clk),
        .rst   (rst),
        .clr   (abort_hit_c),
        .in_en (rd_en_q),
        .en    (row_en)
    );

    skew_line #(.N(N)) u_col_skew (
        .clk   (clk),
        .rst   (rst),
        .clr   (abort_hit_c),
        .in_en (rd_en_q),
        .en    (col_en)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pe_clear  = pe_clear_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.row_en    = row_en;
    assign bus.col_en    = col_en;
    assign bus.out_valid = out_valid_q;
    assign bus.drain_row = drain_row_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    // Saturating operation-length and drain-stall counters, cleared as an operation starts.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (state_q == IDLE && state_d == CLEAR) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else begin
            if (state_q != IDLE && perf_cycles_q != '1) begin
                perf_cycles_d = perf_cycles_q + 32'd1;
            end
            if (state_q == DRAIN && out_valid_q && !bus.out_ready && perf_stalls_q != '1) begin
                perf_stalls_d = perf_stalls_q + 32'd1;
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: scenario table, hand sequences, random traffic vs. a timeline model.
module tb_systolic_ctrl;
    import systolic_pkg::*;

    localparam int N  = 4;
    localparam int K  = 4;
    localparam int PL = 1;
    localparam int F  = 2 * N - 1 + PL;
    localparam int D0 = K + 2 + F;   // first DRAIN cycle, counting CLEAR as cycle 1

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_ctrl_if #(.N(N), .K(K)) sif ();
    systolic_ctrl_if #(.N(1), .K(1)) sif1 ();

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_stalls, perf_cycles1, perf_stalls1;
`endif

    systolic_ctrl #(.N(N), .K(K), .PE_LAT(PL)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SYSTOLIC_CTRL_PERF_EN
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls),
`endif
        .bus         (sif)
    );

    systolic_ctrl #(.N(1), .K(1), .PE_LAT(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
`ifdef SYSTOLIC_CTRL_PERF_EN
        .perf_cycles (perf_cycles1),
        .perf_stalls (perf_stalls1),
`endif
        .bus         (sif1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Timeline model: an operation is a cycle index t (1 = CLEAR) plus rows accepted.
    bit m_active = 1'b0;
    int m_t      = 0;
    int m_acc    = 0;

    int cyc = 0, done_cnt = 0, last_done_cyc = -1, last_clear_cyc = -1;
    int stall_row = -1, stall_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        bit e_drain, e_rd;
        logic [N-1:0] e_row;
        e_drain = m_active && m_t >= D0 && m_acc < N;
        e_rd    = m_active && m_t >= 2 && m_t <= K + 1;
        for (int i = 0; i < N; i++) e_row[i] = m_active && m_t >= 3 + i && m_t <= 2 + i + K;
        check("busy",      32'(sif.busy),      32'(m_active));
        check("done",      32'(sif.done),      32'(m_active && m_acc == N));
        check("pe_clear",  32'(sif.pe_clear),  32'(m_active && m_t == 1));
        check("rd_en",     32'(sif.rd_en),     32'(e_rd));
        if (e_rd) check("rd_addr", 32'(sif.rd_addr), 32'(m_t - 2));
        check("row_en",    32'(sif.row_en),    32'(e_row));
        check("col_en",    32'(sif.col_en),    32'(e_row));
        check("out_valid", 32'(sif.out_valid), 32'(e_drain));
        if (e_drain) check("drain_row", 32'(sif.drain_row), 32'(m_acc));
    endtask

    task automatic model_step(input bit st, input bit ab, input bit rdy);
        if (!m_active) begin
            if (st) begin
                m_active = 1'b1; m_t = 1; m_acc = 0;
            end
        end else if (ab || m_acc == N) begin
            m_active = 1'b0;
        end else begin
            if (m_t >= D0 && rdy) m_acc++;
            m_t++;
        end
    endtask

    // One clock: compare at the falling edge, drive inputs, step the model at the rising edge.
    task automatic cycle(input bit st, input bit ab, input bit rdy);
        bit r;
        @(negedge clk);
        compare_model();
        if (sif.done) begin done_cnt++; last_done_cyc = cyc; end
        if (sif.pe_clear) last_clear_cyc = cyc;
        r = rdy;
        if (stall_left > 0 && sif.out_valid && 32'(sif.drain_row) == stall_row) begin
            r = 1'b0;
            stall_left--;
        end
        sif.start = st; sif.abort = ab; sif.out_ready = r;
        @(posedge clk);
        cyc++;
        model_step(st, ab, r);
    endtask

    typedef struct {
        int stall_row;
        int stall_len;
        int abort_at;
        int exp_done;    // cycle of the done pulse, 0 = never
        int exp_stalls;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int s, nv, nd, nr, nc, nrd, t_done;
        vecs[0] = '{-1, 0, 0, 18, 0};
        vecs[1] = '{ 2, 5, 0, 23, 5};
        vecs[2] = '{ 0, 3, 0, 21, 3};
        vecs[3] = '{ 3, 1, 0, 19, 1};
        vecs[4] = '{-1, 0, 3,  0, 0};
        vecs[5] = '{-1, 0, 0, 18, 0};

        rst = 1'b0;
        sif.start = 1'b0;  sif.abort = 1'b0;  sif.out_ready = 1'b1;
        sif1.start = 1'b0; sif1.abort = 1'b0; sif1.out_ready = 1'b1;
        #12;
        check("rst_busy",      32'(sif.busy),      0);
        check("rst_done",      32'(sif.done),      0);
        check("rst_pe_clear",  32'(sif.pe_clear),  0);
        check("rst_rd_en",     32'(sif.rd_en),     0);
        check("rst_rd_addr",   32'(sif.rd_addr),   0);
        check("rst_row_en",    32'(sif.row_en),    0);
        check("rst_col_en",    32'(sif.col_en),    0);
        check("rst_out_valid", 32'(sif.out_valid), 0);
        check("rst_drain_row", 32'(sif.drain_row), 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
        check("rst_perf_cycles", perf_cycles, 0);
        check("rst_perf_stalls", perf_stalls, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (2) cycle(1'b0, 1'b0, 1'b1);

        // Scenario table: nominal, backpressure, abort, restart after abort.
        foreach (vecs[v]) begin
            done_cnt = 0;
            stall_row = vecs[v].stall_row;
            stall_left = vecs[v].stall_len;
            cycle(1'b1, 1'b0, 1'b1);
            s = cyc;
            for (int t = 1; t <= 40; t++) cycle(1'b0, (t == vecs[v].abort_at), 1'b1);
            check($sformatf("vec%0d_done_cnt", v), 32'(done_cnt), 32'(vecs[v].exp_done != 0));
            if (vecs[v].exp_done != 0) begin
                check($sformatf("vec%0d_done_at", v), 32'(last_done_cyc - s + 1), 32'(vecs[v].exp_done));
`ifdef SYSTOLIC_CTRL_PERF_EN
                check($sformatf("vec%0d_perf_cycles", v), perf_cycles, 32'(vecs[v].exp_done));
                check($sformatf("vec%0d_perf_stalls", v), perf_stalls, 32'(vecs[v].exp_stalls));
`endif
            end
        end
        stall_row = -1; stall_left = 0;

        // start held high: one done per operation, next CLEAR two cycles after done.
        done_cnt = 0;
        for (int t = 0; t < 22; t++) cycle(1'b1, 1'b0, 1'b1);
        check("hold_start_done_cnt", 32'(done_cnt), 1);
        check("hold_start_reclear_gap", 32'(last_clear_cyc - last_done_cyc), 2);
        for (int t = 0; t < 30; t++) cycle(1'b0, 1'b0, 1'b1);

        // Asynchronous reset while parked in DRAIN at row 2.
        stall_row = 2; stall_left = 1000;
        cycle(1'b1, 1'b0, 1'b1);
        for (int t = 0; t < 20; t++) cycle(1'b0, 1'b0, 1'b1);
        check("pre_rst_drain_row", 32'(sif.drain_row), 2);
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(sif.out_valid), 0);
        check("arst_busy",      32'(sif.busy),      0);
        check("arst_drain_row", 32'(sif.drain_row), 0);
        check("arst_row_en",    32'(sif.row_en),    0);
        m_active = 1'b0;
        stall_row = -1; stall_left = 0;
        cycle(1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        done_cnt = 0;
        cycle(1'b1, 1'b0, 1'b1);
        s = cyc;
        for (int t = 0; t < 25; t++) cycle(1'b0, 1'b0, 1'b1);
        check("post_rst_done_at", 32'(last_done_cyc - s + 1), 18);

        // Random traffic against the model.
        for (int t = 0; t < 3000; t++) begin
            cycle(($urandom_range(3) == 0), ($urandom_range(59) == 0), ($urandom_range(9) < 7));
        end
        for (int t = 0; t < 40; t++) cycle(1'b0, 1'b0, 1'b1);

        // Degenerate N=1, K=1 instance.
        @(negedge clk);
        sif1.start = 1'b1;
        @(posedge clk);
        nv = 0; nd = 0; nr = 0; nc = 0; nrd = 0; t_done = 0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            sif1.start = 1'b0;
            if (sif1.done) begin nd++; t_done = t; end
            if (sif1.out_valid) begin
                nv++;
                check("n1_drain_row", 32'(sif1.drain_row), 0);
            end
            if (sif1.row_en[0]) nr++;
            if (sif1.col_en[0]) nc++;
            if (sif1.rd_en) nrd++;
            @(posedge clk);
        end
        check("n1_done_cnt", 32'(nd), 1);
        check("n1_done_at",  32'(t_done), 6);
        check("n1_valid_cycles", 32'(nv), 1);
        check("n1_row_en_cycles", 32'(nr), 1);
        check("n1_col_en_cycles", 32'(nc), 1);
        check("n1_rd_en_cycles", 32'(nrd), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
